// File: rtl/in_port_pkg.sv
// Shared constants for the in_port peripheral: bus width and the
// bit positions of the status byte.
package in_port_pkg;

  localparam int DW           = 8;
  localparam int STAT_OVR     = 7;
  localparam int STAT_FULL    = 6;
  localparam int STAT_NEMPTY  = 5;
  localparam int STAT_CNT_LSB = 0;

endpackage

// File: rtl/in_port_fifo.sv
// Small register-file FIFO used by in_port.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module in_fifo
  import in_port_pkg::*;
#(
  parameter int DW    = in_port_pkg::DW,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          t4,
  input  logic          nrst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_pop;
  logic          do_push;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  // Storage is deliberately not reset; a push on a reset edge is discarded.
  always_ff @(posedge t4) begin
    if (nrst && do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge t4) begin
    if (!nrst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/in_port.sv
// Input port peripheral: captures strobed device bytes into a FIFO and
// returns the head byte or a status byte on the shared tri-state CPU bus.
module in_port
  import in_port_pkg::*;
#(
  parameter int DW    = in_port_pkg::DW,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          t4,
  input  logic          nrst,
  inout  logic [DW-1:0] bus,
  input  logic          nsw_bus,
  input  logic          ce,
  input  logic          we,
  input  logic          a0,
  input  logic [DW-1:0] dev_data,
  input  logic          dev_stb,
  output logic          dev_rdy,
  output logic          irq
);

  logic          rd;
  logic          pop_req;
  logic          push_req;
  logic          overrun;
  logic          stb_q;
  logic          ovr;
  logic [DW-1:0] fifo_head;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic [DW-1:0] status;
  logic [DW-1:0] bus_val;

  assign rd       = nsw_bus & ~ce & ~we;
  assign pop_req  = rd & ~a0;
  assign push_req = dev_stb & ~stb_q;
  assign overrun  = push_req & full & ~(pop_req & ~empty);

  in_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .t4      (t4),
    .nrst    (nrst),
    .push    (push_req),
    .pop     (pop_req),
    .wr_data (dev_data),
    .rd_data (fifo_head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // stb_q resets high so a strobe already asserted during reset is not taken as an edge.
  always_ff @(posedge t4) begin
    if (!nrst) begin
      stb_q <= 1'b1;
      ovr   <= 1'b0;
    end else begin
      stb_q <= dev_stb;
      if (overrun) begin
        ovr <= 1'b1;
      end else if (rd & a0) begin
        ovr <= 1'b0;
      end
    end
  end

  always_comb begin
    status                        = '0;
    status[STAT_OVR]              = ovr;
    status[STAT_FULL]             = full;
    status[STAT_NEMPTY]           = ~empty;
    status[STAT_CNT_LSB +: CW]    = count;
  end

  assign bus_val = a0 ? status : (empty ? '0 : fifo_head);
  assign bus     = rd ? bus_val : 'z;

  assign dev_rdy = ~full;
  assign irq     = ~empty;

endmodule

// File: tb/tb_in_port.sv
// Self-checking bench for in_port: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based model.
module tb_in_port;

  localparam int DEPTH = 4;

  logic       t4 = 1'b0;
  logic       nrst = 1'b0;
  wire  [7:0] bus;
  logic       nsw_bus = 1'b1;
  logic       ce = 1'b1;
  logic       we = 1'b1;
  logic       a0 = 1'b0;
  logic [7:0] dev_data = 8'h00;
  logic       dev_stb = 1'b1;
  logic       dev_rdy;
  logic       irq;

  int errors = 0;
  int checks = 0;

  // An undriven bus reads back as all ones, so released looks like 0xFF.
  pullup (bus);

  in_port #(.DW(8), .DEPTH(DEPTH), .CW(3)) dut (
    .t4       (t4),
    .nrst     (nrst),
    .bus      (bus),
    .nsw_bus  (nsw_bus),
    .ce       (ce),
    .we       (we),
    .a0       (a0),
    .dev_data (dev_data),
    .dev_stb  (dev_stb),
    .dev_rdy  (dev_rdy),
    .irq      (irq)
  );

  always #5 t4 = ~t4;

  logic [7:0] mq[$];
  logic       m_ovr = 1'b0;
  logic       m_stb = 1'b1;
  bit         model_valid = 1'b0;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, updated from the inputs seen at each edge.
  always @(posedge t4) begin
    logic m_rd;
    logic m_push;
    if (!nrst) begin
      mq.delete();
      m_ovr       = 1'b0;
      m_stb       = 1'b1;
      model_valid = 1'b1;
    end else if (model_valid) begin
      m_rd   = nsw_bus && !ce && !we;
      m_push = dev_stb && !m_stb;
      if (m_rd && !a0 && mq.size() > 0) void'(mq.pop_front());
      if (m_rd && a0) m_ovr = 1'b0;
      if (m_push) begin
        if (mq.size() < DEPTH) mq.push_back(dev_data);
        else m_ovr = 1'b1;
      end
      m_stb = dev_stb;
    end
  end

  // Compare process: outputs are checked against the model on every falling edge.
  always @(negedge t4) begin
    logic [7:0] exp_bus;
    logic [2:0] cnt;
    if (model_valid) begin
      cnt = 3'(mq.size());
      if (nsw_bus && !ce && !we) begin
        if (a0) exp_bus = {m_ovr, mq.size() == DEPTH, mq.size() != 0, 2'b00, cnt};
        else    exp_bus = (mq.size() == 0) ? 8'h00 : mq[0];
      end else begin
        exp_bus = 8'hFF;
      end
      checkOutput("model_bus", bus, exp_bus);
      checkOutput("model_dev_rdy", {7'b0, dev_rdy}, {7'b0, mq.size() < DEPTH});
      checkOutput("model_irq", {7'b0, irq}, {7'b0, mq.size() != 0});
    end
  end

  // Sets inputs just after a rising edge and returns at the following falling edge.
  task automatic applyStimulus(input logic n, input logic nsw, input logic ce_i, input logic we_i,
                               input logic a0_i, input logic stb, input logic [7:0] d);
    @(posedge t4);
    #1;
    nrst     = n;
    nsw_bus  = nsw;
    ce       = ce_i;
    we       = we_i;
    a0       = a0_i;
    dev_stb  = stb;
    dev_data = d;
    @(negedge t4);
  endtask

  // op: 0 = idle, 1 = data read, 2 = status read
  task automatic cyc(input logic stb, input logic [7:0] d, input int op);
    applyStimulus(1'b1, 1'b1, op == 0, 1'b0, op == 2, stb, d);
  endtask

  initial begin
    logic [7:0] fill [4];
    logic [7:0] simul [4];
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;
    simul[0] = 8'h22; simul[1] = 8'h33; simul[2] = 8'h44; simul[3] = 8'h99;

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
    checkOutput("rst_dev_rdy", {7'b0, dev_rdy}, 8'h01);
    checkOutput("rst_irq", {7'b0, irq}, 8'h00);
    checkOutput("rst_bus_z", bus, 8'hFF);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    checkOutput("rst_stb_held_status", bus, 8'h00);
    checkOutput("rst_stb_held_irq", {7'b0, irq}, 8'h00);

    cyc(1'b0, 8'h00, 0);
    cyc(1'b1, 8'hA5, 0);
    cyc(1'b0, 8'h00, 2);
    checkOutput("single_status", bus, 8'h21);
    checkOutput("single_irq", {7'b0, irq}, 8'h01);
    cyc(1'b0, 8'h00, 1);
    checkOutput("single_data", bus, 8'hA5);
    cyc(1'b0, 8'h00, 2);
    checkOutput("single_status_after", bus, 8'h00);
    checkOutput("single_irq_after", {7'b0, irq}, 8'h00);

    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, fill[i], 0);
      cyc(1'b0, 8'h00, 0);
    end
    cyc(1'b0, 8'h00, 2);
    checkOutput("fill_status", bus, 8'h64);
    checkOutput("fill_dev_rdy", {7'b0, dev_rdy}, 8'h00);
    cyc(1'b1, 8'h55, 0);
    cyc(1'b0, 8'h00, 2);
    checkOutput("ovr_status", bus, 8'hE4);
    checkOutput("ovr_dev_rdy", {7'b0, dev_rdy}, 8'h00);
    cyc(1'b0, 8'h00, 2);
    checkOutput("ovr_cleared_status", bus, 8'h64);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 8'h00, 1);
      checkOutput($sformatf("drain_data%0d", i), bus, fill[i]);
    end

    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, fill[i], 0);
      cyc(1'b0, 8'h00, 0);
    end
    cyc(1'b1, 8'h99, 1);
    checkOutput("simul_head", bus, 8'h11);
    cyc(1'b0, 8'h00, 2);
    checkOutput("simul_status", bus, 8'h64);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 8'h00, 1);
      checkOutput($sformatf("simul_data%0d", i), bus, simul[i]);
    end

    cyc(1'b1, 8'h77, 0);
    cyc(1'b0, 8'h00, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("own_nsw_bus_z", bus, 8'hFF);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("own_we_bus_z", bus, 8'hFF);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("own_ce_bus_z", bus, 8'hFF);
    cyc(1'b0, 8'h00, 2);
    checkOutput("own_status", bus, 8'h21);
    cyc(1'b0, 8'h00, 1);
    checkOutput("own_data", bus, 8'h77);
    cyc(1'b0, 8'h00, 1);
    checkOutput("empty_data", bus, 8'h00);
    cyc(1'b0, 8'h00, 2);
    checkOutput("empty_status", bus, 8'h00);

    for (int i = 1; i <= 10; i++) begin
      cyc(1'b1, 8'(i), 0);
      cyc(1'b0, 8'h00, 1);
      checkOutput($sformatf("wrap_data%0d", i), bus, 8'(i));
    end
    cyc(1'b0, 8'h00, 2);
    checkOutput("wrap_status", bus, 8'h00);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 39) != 0, $urandom_range(0, 7) != 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 3) == 0, 1'($urandom), 8'($urandom));
    end
    cyc(1'b0, 8'h00, 0);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
